// File: rtl/lab_pkg.sv
// Constants shared by the counter, FIFO and drain stages of the lab datapath.
package lab_pkg;

  localparam int BYTE_WIDTH = 8;
  localparam int FIFO_DEPTH = 16;

endpackage

// File: rtl/byte_fifo_mem.sv
// DEPTH x DATA_WIDTH storage: registered write port, asynchronous read port.
// No latency on read, one edge on write; no flow control of its own.
module byte_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  // Left uninitialised and without reset so it can map onto distributed RAM.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/byte_fifo.sv
// First-word-fall-through byte FIFO: zero read latency, write visible one edge later.
// Writes while full are dropped and latch overflow; the head is held until out_ready.
module byte_fifo
  import lab_pkg::*;
#(
  parameter int DATA_WIDTH        = BYTE_WIDTH,
  parameter int DEPTH             = FIFO_DEPTH,
  parameter int ALMOST_FULL_LEVEL = 12
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [DATA_WIDTH-1:0]  data_in,
  output logic                   full,
  output logic                   almost_full,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_LEVEL = (ADDR_WIDTH + 1)'(ALMOST_FULL_LEVEL);

  // Extra MSB on each pointer is the wrap bit that separates full from empty.
  logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic                overflow_q, overflow_d;
  logic                empty;
  logic                wr_accept;
  logic                pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                 (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);

  assign count       = wr_ptr_q - rd_ptr_q;
  assign almost_full = (count >= AF_LEVEL);
  assign out_valid   = ~empty;
  assign overflow    = overflow_q;

  // Full is taken from pre-edge state, so a same-cycle pop never rescues a write.
  assign wr_accept = wr_en & ~full;
  assign pop       = out_valid & out_ready;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q | (wr_en & full);
    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  byte_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_accept & ~reset),
    .waddr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wdata_i (data_in),
    .raddr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rdata_o (data_out)
  );

endmodule

// File: tb/tb_byte_fifo.sv
// Self-checking bench for byte_fifo: directed scenarios plus random traffic against a queue model.
module tb_byte_fifo;

  localparam int DEPTH = 16;
  localparam int AFL   = 12;

  logic       clk;
  logic       reset;
  logic       wr_en;
  logic [7:0] data_in;
  logic       full;
  logic       almost_full;
  logic [7:0] data_out;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] count;
  logic       overflow;

  int errors = 0;
  int checks = 0;

  logic [7:0] mq[$];
  bit         movf;

  byte_fifo #(
    .DATA_WIDTH        (8),
    .DEPTH             (DEPTH),
    .ALMOST_FULL_LEVEL (AFL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .data_in     (data_in),
    .full        (full),
    .almost_full (almost_full),
    .data_out    (data_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .count       (count),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] exp_count();
    return 5'(mq.size());
  endfunction

  // Drive one cycle, advance the queue model by the behavioural rules, sample #1 after the edge.
  task automatic cycle(input bit rst, input bit wr, input logic [7:0] din, input bit rdy);
    bit was_full;
    reset     = rst;
    wr_en     = wr;
    data_in   = din;
    out_ready = rdy;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      movf = 1'b0;
    end else begin
      was_full = (mq.size() == DEPTH);
      if (wr && was_full) movf = 1'b1;
      if (rdy && mq.size() > 0) void'(mq.pop_front());
      if (wr && !was_full) mq.push_back(din);
    end
    #1;
  endtask

  task automatic test_reset();
    cycle(1, 1, 8'hFF, 1);
    cycle(1, 0, 8'h00, 0);
    cycle(0, 0, 8'h00, 0);
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b want=0", full); end
    checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_afull got=%b want=0", almost_full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b want=0", overflow); end
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 8'h00, 1);
      checks++; if (count !== 5'd0) begin errors++; $display("FAIL idle_pop_count got=%0d want=0", count); end
    end
  endtask

  task automatic test_single_fwft();
    cycle(0, 1, 8'h05, 0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fwft_valid got=%b want=1", out_valid); end
    checks++; if (data_out !== 8'h05) begin errors++; $display("FAIL fwft_data got=%h want=05", data_out); end
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL fwft_count got=%0d want=1", count); end
    cycle(0, 0, 8'h00, 1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fwft_pop_valid got=%b want=0", out_valid); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL fwft_pop_count got=%0d want=0", count); end
  endtask

  task automatic test_fill_overflow();
    logic [7:0] v;
    for (int i = 0; i < DEPTH; i++) begin
      v = 8'(i);
      cycle(0, 1, v, 0);
      checks++; if (count !== 5'(i + 1)) begin errors++; $display("FAIL fill_count got=%0d want=%0d", count, i + 1); end
      checks++; if (almost_full !== (i + 1 >= AFL)) begin errors++; $display("FAIL fill_afull n=%0d got=%b", i + 1, almost_full); end
      checks++; if (full !== (i + 1 == DEPTH)) begin errors++; $display("FAIL fill_full n=%0d got=%b", i + 1, full); end
    end
    cycle(0, 1, 8'hAA, 0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL drop_ovf got=%b want=1", overflow); end
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL drop_count got=%0d want=16", count); end
    for (int i = 0; i < DEPTH; i++) begin
      v = 8'(i);
      checks++; if (out_valid !== 1'b1 || data_out !== v) begin errors++; $display("FAIL drain_data i=%0d got=%h/%b want=%h", i, data_out, out_valid, v); end
      cycle(0, 0, 8'h00, 1);
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got=%b want=0", out_valid); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b want=1", overflow); end
  endtask

  task automatic test_wrap_stream();
    logic [7:0] base;
    logic [7:0] v;
    base = 8'($urandom_range(0, 255));
    cycle(0, 1, base, 0);
    for (int i = 1; i < 40; i++) begin
      v = base + 8'(i);
      // Before the edge the head must be the previous input byte.
      checks++; if (data_out !== v - 8'd1) begin errors++; $display("FAIL wrap_popped i=%0d got=%h want=%h", i, data_out, v - 8'd1); end
      cycle(0, 1, v, 1);
      checks++; if (count !== 5'd1) begin errors++; $display("FAIL wrap_count i=%0d got=%0d want=1", i, count); end
    end
    checks++; if (data_out !== base + 8'd39) begin errors++; $display("FAIL wrap_last got=%h want=%h", data_out, base + 8'd39); end
    cycle(0, 0, 8'h00, 1);
  endtask

  task automatic test_full_pop_write();
    logic [7:0] second;
    cycle(1, 0, 8'h00, 0);
    cycle(0, 0, 8'h00, 0);
    for (int i = 0; i < DEPTH; i++) cycle(0, 1, 8'($urandom_range(0, 255)), 0);
    second = mq[1];
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fpw_pre_full got=%b want=1", full); end
    cycle(0, 1, 8'h77, 1);
    checks++; if (count !== 5'd15) begin errors++; $display("FAIL fpw_count got=%0d want=15", count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fpw_ovf got=%b want=1", overflow); end
    checks++; if (data_out !== second) begin errors++; $display("FAIL fpw_head got=%h want=%h", data_out, second); end
    while (mq.size() > 0) begin
      checks++; if (data_out !== mq[0]) begin errors++; $display("FAIL fpw_drain got=%h want=%h", data_out, mq[0]); end
      cycle(0, 0, 8'h00, 1);
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fpw_empty got=%b want=0", out_valid); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < DEPTH + 1; i++) cycle(0, 1, 8'($urandom_range(0, 255)), 0);
    for (int i = 0; i < 7; i++) cycle(0, 0, 8'h00, 1);
    checks++; if (count !== 5'd9 || overflow !== 1'b1) begin errors++; $display("FAIL rmid_pre got=%0d/%b want=9/1", count, overflow); end
    cycle(1, 1, 8'h3C, 0);
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL rmid_count got=%0d want=0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got=%b want=0", out_valid); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rmid_ovf got=%b want=0", overflow); end
    cycle(0, 0, 8'h00, 1);
    checks++; if (count !== 5'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL rmid_nostore got=%0d/%b want=0/0", count, out_valid); end
  endtask

  task automatic test_random();
    int wr_pct;
    int rd_pct;
    for (int blk = 0; blk < 8; blk++) begin
      // Alternate write-heavy and read-heavy phases to visit full and empty often.
      wr_pct = blk[0] ? 30 : 80;
      rd_pct = blk[0] ? 80 : 30;
      for (int i = 0; i < 80; i++) begin
        cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) < wr_pct),
              8'($urandom_range(0, 255)), ($urandom_range(0, 99) < rd_pct));
        checks++; if (count !== exp_count()) begin errors++; $display("FAIL rnd_count got=%0d want=%0d", count, exp_count()); end
        checks++; if (out_valid !== (mq.size() > 0)) begin errors++; $display("FAIL rnd_valid got=%b want=%b", out_valid, mq.size() > 0); end
        checks++; if (full !== (mq.size() == DEPTH)) begin errors++; $display("FAIL rnd_full got=%b", full); end
        checks++; if (almost_full !== (mq.size() >= AFL)) begin errors++; $display("FAIL rnd_afull got=%b", almost_full); end
        checks++; if (overflow !== movf) begin errors++; $display("FAIL rnd_ovf got=%b want=%b", overflow, movf); end
        if (mq.size() > 0) begin
          checks++; if (data_out !== mq[0]) begin errors++; $display("FAIL rnd_data got=%h want=%h", data_out, mq[0]); end
        end
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    wr_en     = 1'b0;
    data_in   = 8'h00;
    out_ready = 1'b0;
    movf      = 1'b0;
    test_reset();
    test_single_fwft();
    test_fill_overflow();
    test_wrap_stream();
    test_full_pop_write();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/byte_fifo.md
Name: byte_fifo

Overview:
- Synchronous single-clock FIFO that buffers bytes produced by the button-press counter stage and hands them to downstream consumers (display/UART drain).
- Write side is a simple strobe with a full indication. Read side is first-word-fall-through with a valid/ready handshake.
- Provides occupancy count, almost-full warning and a sticky overflow flag for debug LEDs.

Parameters:
- DATA_WIDTH, 8, width of each stored word.
- DEPTH, 16, number of entries; must be a power of two, minimum 2.
- ALMOST_FULL_LEVEL, 12, occupancy at or above which almost_full asserts; range 1..DEPTH.
- ADDR_WIDTH, log2(DEPTH), derived localparam, not overridable.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- wr_en  input  1  write strobe; one word offered per asserted cycle.
- data_in  input  DATA_WIDTH  write data, sampled when wr_en=1.
- full  output  1  high when count==DEPTH.
- almost_full  output  1  high when count>=ALMOST_FULL_LEVEL.
- data_out  output  DATA_WIDTH  head-of-queue word; meaningful only while out_valid=1.
- out_valid  output  1  high when count>0.
- out_ready  input  1  consumer accepts the head word this cycle.
- count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky; set when a write is dropped.

Behaviour:
- Reset (reset=1 at a clock edge): write pointer=0, read pointer=0, count=0, overflow=0. Hence out_valid=0, full=0, almost_full=0. Storage contents are not cleared. data_out is don't-care after reset.
- Reset has priority over every other input in the same cycle. A reset asserted mid-operation discards all queued data in one cycle.
- Pointers are ADDR_WIDTH+1 bits; the MSB is the wrap bit.
  - empty: pointers equal.
  - full: low bits equal and MSBs differ.
  - count = wr_ptr - rd_ptr, modulo 2^(ADDR_WIDTH+1).
- Write accept: wr_en=1 and full=0. data_in is stored at mem[wr_ptr low bits] and wr_ptr increments.
- Write drop: wr_en=1 and full=1. Nothing is stored, pointers are unchanged, overflow is set to 1.
  - This holds even if a pop occurs in the same cycle; full is evaluated on pre-edge state.
- Pop: out_valid=1 and out_ready=1. rd_ptr increments.
  - out_ready while out_valid=0 is ignored, so no underflow is possible.
- FWFT read path: data_out is combinational from mem[rd_ptr low bits]. No read latency.
- Write-to-valid latency: a word written into an empty FIFO at edge N is visible on data_out, with out_valid=1, after edge N.
- Simultaneous accepted write and pop: count unchanged. Both pointers advance.
  - When count==1, the new word becomes head after the edge.
- Pointer wrap: after DEPTH writes, low bits return to 0 and the wrap bit toggles. Ordering is strictly preserved across the wrap.
- overflow is cleared only by reset.
- full, almost_full, out_valid and count are all derived from registered pointers. There are no combinational paths from wr_en or out_ready to any output.

Decomposition:
- Shared package lab_pkg: BYTE_WIDTH=8 and the default FIFO depth constant, reused by the counter stage and drain stages. Also a clog2 helper function if the toolchain lacks $clog2.
- One sub-module, byte_fifo_mem: DEPTH x DATA_WIDTH array with registered write and asynchronous read port, so it can later be mapped to distributed RAM. Pointer, flag and count logic stays in byte_fifo.

Test Plan:
- Reset then idle:
  - Hold reset 2 cycles, release.
  - Required: count=0, out_valid=0, full=0, almost_full=0, overflow=0.
  - out_ready=1 pulses leave count at 0.
- Single word FWFT:
  - Write 0x05 one cycle on an empty FIFO.
  - Required: the next cycle gives out_valid=1, data_out=0x05, count=1.
  - Assert out_ready one cycle; then out_valid=0, count=0.
- Fill and overflow:
  - Write 0x00..0x0F (16 words) with out_ready=0.
  - Required: almost_full rises when count reaches 12, and full=1 at count=16.
  - Write 0xAA; it is dropped, overflow=1, count stays 16.
  - Draining yields exactly 0x00..0x0F in order.
- Wrap-around with concurrent traffic:
  - Stream 40 incrementing bytes with wr_en=1 every cycle and out_ready=1 every cycle after the first.
  - Required: count stays at 1, and output sequence equals input sequence across two pointer wraps.
- Full plus simultaneous pop and write:
  - At count=16 assert wr_en=1 (data 0x77) and out_ready=1 together.
  - Required: head popped, 0x77 dropped, overflow=1, count=15.
- Reset mid-operation:
  - With count=9 and overflow=1, assert reset while wr_en=1.
  - Required: next cycle count=0, out_valid=0, overflow=0, and the write is not stored.
